// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: stream controller for a free-running systolic FIR chain.
// Handshake in, tagged chain head drive, tail capture into FIFO, credit flow.
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   in_valid/in_data       upstream sample stream (in_ready back)
//   flush / flush_busy     drain request / drain in progress
//   chain_x, chain_y       chain head inputs (x registered, y tied 0)
//   chain_yout             chain tail output
//   out_valid/out_data     filtered output stream (out_ready back)
//
// Optional feature macro: FIR_STREAM_FLUSH_EN (flush sequence).
module fir_stream_ctrl #(
    parameter int BITS       = 16,
    parameter int TAPS       = 8,
    parameter int CHAIN_LAT  = 24,
    parameter int FIFO_DEPTH = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    input  logic            flush,
    output logic            flush_busy,
    output logic [BITS-1:0] chain_x,
    output logic [BITS-1:0] chain_y,
    input  logic [BITS-1:0] chain_yout,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    input  logic            out_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state;
    logic [CW-1:0]       credits;
    // tags[0] lines up with chain_x; tags[CHAIN_LAT] with chain_yout
    logic [CHAIN_LAT:0]  tags;
    logic                accept;
    logic                inject;
    logic                push;
    logic                pop;
    logic                wr;
    logic                head_free;
    logic                mem_wr;
    logic                mem_rd;
    logic [BITS-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;

    assign in_ready = (credits != '0) && (state != FLUSH);
    assign accept   = in_valid && in_ready;
    assign push     = accept || inject;
    assign pop      = out_valid && out_ready;
    assign wr       = tags[CHAIN_LAT];
    assign chain_y  = '0;

    // Head register refills from backing store first, else bypasses a write
    assign head_free = !out_valid || out_ready;
    assign mem_rd    = head_free && (count != '0);
    assign mem_wr    = wr && !(head_free && (count == '0));

`ifdef FIR_STREAM_FLUSH_EN
    localparam int FW = (TAPS > 2) ? $clog2(TAPS - 1) : 1;

    logic [FW-1:0] fcnt;

    assign inject     = (state == FLUSH) && (credits != '0);
    assign flush_busy = (state == FLUSH);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            fcnt  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) state <= RUN;
                RUN: begin
                    if (flush) begin
                        fcnt  <= '0;
                        state <= (TAPS > 1) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    if (inject) begin
                        if (fcnt == FW'(TAPS - 2)) state <= IDLE;
                        else fcnt <= fcnt + FW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    localparam int unused_taps = TAPS;

    logic unused_flush;

    assign unused_flush = flush;
    assign inject       = 1'b0;
    assign flush_busy   = 1'b0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= RUN;
                RUN:     state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            credits <= CW'(FIFO_DEPTH);
            tags    <= '0;
            chain_x <= '0;
        end else begin
            case ({push, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
            tags    <= {tags[CHAIN_LAT-1:0], push};
            chain_x <= accept ? in_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) mem[wr_ptr] <= chain_yout;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (head_free) begin
                if (count != '0) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (wr) begin
                    out_data  <= chain_yout;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (mem_rd) rd_ptr <= rd_ptr + AW'(1);
            if (mem_wr) wr_ptr <= wr_ptr + AW'(1);
            case ({mem_wr, mem_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: directed bench for fir_stream_ctrl.
// Chain is modelled as a pure CHAIN_LAT-cycle delay of chain_x.
module tb_fir_stream_ctrl;

    localparam int BITS  = 16;
    localparam int TAPS  = 8;
    localparam int LAT   = 24;
    localparam int DEPTH = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic            flush_busy;
    logic [BITS-1:0] chain_x;
    logic [BITS-1:0] chain_y;
    logic [BITS-1:0] chain_yout;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_ready = 1'b1;

    fir_stream_ctrl #(
        .BITS(BITS), .TAPS(TAPS), .CHAIN_LAT(LAT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .flush(flush), .flush_busy(flush_busy),
        .chain_x(chain_x), .chain_y(chain_y), .chain_yout(chain_yout),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    logic [BITS-1:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= chain_x;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign chain_yout = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BITS-1:0] outq [$];
    int outcyc [$];
    int acccyc [$];
    int acc_cnt = 0;
    int busy_cnt = 0;
    bit seen_valid = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (in_valid && in_ready) begin
                acc_cnt++;
                acccyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                outq.push_back(out_data);
                outcyc.push_back(cyc);
            end
            if (out_valid) seen_valid = 1;
            if (flush_busy) busy_cnt++;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        outq.delete();
        outcyc.delete();
        acccyc.delete();
        acc_cnt = 0;
        busy_cnt = 0;
        seen_valid = 0;
    endtask

    function automatic logic [31:0] outq_at(input int i);
        if (i < outq.size()) return 32'(outq[i]);
        return 32'hxxxxxxxx;
    endfunction

    function automatic int first_latency();
        if (outcyc.size() == 0 || acccyc.size() == 0) return -1;
        return outcyc[0] - acccyc[0];
    endfunction

    typedef struct {
        logic            iv;
        logic [BITS-1:0] d;
        logic [BITS-1:0] exp_x;
        logic            exp_rdy;
    } vec_t;

    vec_t tv [6];
    logic [BITS-1:0] tv_out [4];

    initial begin
        int errs;
        int drops;

        tv[0] = '{1'b1, 16'h1111, 16'h1111, 1'b1};
        tv[1] = '{1'b0, 16'h2222, 16'h0000, 1'b1};
        tv[2] = '{1'b1, 16'h3333, 16'h3333, 1'b1};
        tv[3] = '{1'b1, 16'h4444, 16'h4444, 1'b1};
        tv[4] = '{1'b0, 16'h5555, 16'h0000, 1'b1};
        tv[5] = '{1'b1, 16'h5555, 16'h5555, 1'b1};
        tv_out[0] = 16'h1111;
        tv_out[1] = 16'h3333;
        tv_out[2] = 16'h4444;
        tv_out[3] = 16'h5555;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        chk("rst_chain_x", 32'(chain_x), 32'd0);
        chk("rst_chain_y", 32'(chain_y), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick();
        rstn = 1'b1;
        clear_mon();

        // table: accepts and zero-stuffed gaps on chain_x
        for (int i = 0; i < 6; i++) begin
            in_valid = tv[i].iv;
            in_data  = tv[i].d;
            tick();
            chk($sformatf("tbl_x%0d", i), 32'(chain_x), 32'(tv[i].exp_x));
            chk($sformatf("tbl_rdy%0d", i), 32'(in_ready), 32'(tv[i].exp_rdy));
        end
        in_valid = 1'b0;
        repeat (40) tick();
        chk("tbl_count", 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("tbl_out%0d", i), outq_at(i), 32'(tv_out[i]));

        // single sample latency
        clear_mon();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk("single_chain_x", 32'(chain_x), 32'h1234);
        repeat (40) tick();
        chk("single_count", 32'(outq.size()), 32'd1);
        chk("single_data", outq_at(0), 32'h1234);
        chk("single_latency", 32'(first_latency()), 32'(LAT + 2));

        // 100 back-to-back samples
        clear_mon();
        drops = 0;
        for (int k = 1; k <= 100; k++) begin
            in_valid = 1'b1;
            in_data  = BITS'(k);
            @(negedge clk);
            if (!in_ready) drops++;
            tick();
        end
        in_valid = 1'b0;
        for (int w = 0; w < 80 && outq.size() < 100; w++) tick();
        repeat (5) tick();
        chk("b2b_drops", 32'(drops), 32'd0);
        chk("b2b_count", 32'(outq.size()), 32'd100);
        errs = 0;
        for (int i = 0; i < outq.size(); i++) begin
            if (outq[i] !== BITS'(i + 1)) errs++;
            if (outcyc[i] != outcyc[0] + i) errs++;
        end
        chk("b2b_order_contig", 32'(errs), 32'd0);
        chk("b2b_latency", 32'(first_latency()), 32'(LAT + 2));

        // backpressure: full FIFO halts input only
        clear_mon();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            in_data = BITS'(16'h0100 + acc_cnt);
            tick();
        end
        chk("bp_accepted", 32'(acc_cnt), 32'(DEPTH));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            in_data = BITS'(16'h0100 + acc_cnt);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_resumed", 32'(acc_cnt > DEPTH), 32'd1);
        for (int w = 0; w < 80 && outq.size() < acc_cnt; w++) tick();
        repeat (5) tick();
        chk("bp_count", 32'(outq.size()), 32'(acc_cnt));
        errs = 0;
        for (int i = 0; i < outq.size(); i++)
            if (outq[i] !== BITS'(16'h0100 + i)) errs++;
        chk("bp_order", 32'(errs), 32'd0);

`ifdef FIR_STREAM_FLUSH_EN
        // accept plus flush in the same RUN cycle
        clear_mon();
        in_valid = 1'b1;
        in_data  = 16'h0AAA;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("fl_chain_x", 32'(chain_x), 32'h0AAA);
        chk("fl_busy_hi", 32'(flush_busy), 32'd1);
        chk("fl_in_ready", 32'(in_ready), 32'd0);
        repeat (40) tick();
        chk("fl_busy_cycles", 32'(busy_cnt), 32'(TAPS - 1));
        chk("fl_count", 32'(outq.size()), 32'(TAPS));
        chk("fl_first", outq_at(0), 32'h0AAA);
        errs = 0;
        for (int i = 1; i < outq.size(); i++)
            if (outq[i] !== '0) errs++;
        chk("fl_zeros", 32'(errs), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idle_ignored", 32'(flush_busy), 32'd0);
        chk("fl_idle_ready", 32'(in_ready), 32'd1);
`else
        // flush is inert when the feature is not built
        clear_mon();
        in_valid = 1'b1;
        in_data  = 16'h0BBB;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("nofl_busy", 32'(flush_busy), 32'd0);
        chk("nofl_in_ready", 32'(in_ready), 32'd1);
        repeat (40) tick();
        chk("nofl_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("nofl_count", 32'(outq.size()), 32'd1);
        chk("nofl_data", outq_at(0), 32'h0BBB);
`endif

        // reset with samples in flight
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = BITS'(16'h0500 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        rstn = 1'b0;
        @(negedge clk);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_flush_busy", 32'(flush_busy), 32'd0);
        chk("mr_chain_x", 32'(chain_x), 32'd0);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_out_data", 32'(out_data), 32'd0);
        tick();
        rstn = 1'b1;
        clear_mon();
        repeat (40) tick();
        chk("mr_no_stale_valid", 32'(seen_valid), 32'd0);
        chk("mr_no_outputs", 32'(outq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Stream-side controller for a free-running systolic FIR tap chain. It drives the chain head: accepts samples over a valid/ready handshake, presents them on `chain_x`, and tags each one along a latency-matched valid delay line. It collects the chain tail output `chain_yout` into an output FIFO and applies credit-based backpressure, because the chain itself cannot stall. It sits between the upstream sample source and the downstream consumer; the tap chain hangs off its `chain_*` ports.

## Interface
- `BITS`, 16, sample/coefficient word width (matches chain `BITS`)
- `TAPS`, 8, number of taps in the chain; sets flush length
- `CHAIN_LAT`, 24, cycles from `chain_x` change to the matching result on `chain_yout` (≥1)
- `FIFO_DEPTH`, 32, output FIFO entries; power of two, ≥ 2

- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream sample valid
- `in_data`  in  BITS  upstream sample
- `in_ready`  out  1  controller accepts sample this cycle
- `flush`  in  1  single-cycle request to drain the chain after the last sample
- `flush_busy`  out  1  flush sequence in progress
- `chain_x`  out  BITS  chain head x input (registered)
- `chain_y`  out  BITS  chain head y input; constant 0
- `chain_yout`  in  BITS  chain tail y output
- `out_valid`  out  1  FIFO head valid
- `out_data`  out  BITS  filtered output
- `out_ready`  in  1  downstream accepts output

## Operation
- Accept: `in_valid && in_ready`. Next cycle `chain_x` = `in_data`, and tag=1 enters the delay line.
- Gap cycles (no accept, not flushing): `chain_x` ← 0, tag=0. The filter sees zero-stuffed input; outputs for those cycles are dropped.
- Delay line: `CHAIN_LAT`-deep shift register of tags, shifts every cycle. When the exiting tag is 1, `chain_yout` is written into the FIFO that cycle.
- Credits: counter reset to `FIFO_DEPTH`.
  - Decrements on each tagged push into the chain (accepted sample or flush sample).
  - Increments on `out_valid && out_ready`.
  - Both in the same cycle: unchanged.
  - `in_ready` = (credits ≠ 0) && state ≠ FLUSH. This guarantees the FIFO never overflows; a full FIFO with `out_ready` low halts input only.
- FSM states:
  - IDLE (reset): accept moves to RUN. `flush` is ignored.
  - RUN: `flush` moves to FLUSH. If an accept occurs in the same cycle as `flush`, the sample is taken first.
  - FLUSH: injects `TAPS-1` zero samples with tag=1. Each injection consumes a credit and waits while credits = 0. After the last injection, go to IDLE. `flush` is ignored while in FLUSH.
- `flush_busy` = (state == FLUSH).
- FIFO: registered head. Simultaneous write and read are allowed at any occupancy, including full-with-read and empty-with-write.
- Reset mid-operation clears the FSM, credits, tags, FIFO and `chain_x` immediately. Data in the chain is discarded because all tags are cleared.

## Timing
- Reset values: `in_ready`=1, `flush_busy`=0, `chain_x`=0, `chain_y`=0, `out_valid`=0, `out_data`=0.
- Accept at cycle t → `chain_x` valid at t+1 → FIFO write at t+1+`CHAIN_LAT` → `out_valid` at t+2+`CHAIN_LAT`. Minimum latency is `CHAIN_LAT`+2.
- Sustained throughput is 1 sample/cycle while `out_ready`=1.
- The credit update is visible in `in_ready` on the next cycle.
- FLUSH lasts at least `TAPS-1` cycles.

## Configuration
- `FIR_STREAM_FLUSH_EN` defined:
  - FLUSH state and flush counter are present.
  - `flush` behaves as above.
- Not defined:
  - FLUSH state is not built; `flush` is ignored.
  - `flush_busy` is tied to 0.
  - The FSM is reduced to IDLE/RUN, and tail outputs only appear when later samples push them out.

## Test plan
Bench chain model is a pure `CHAIN_LAT`-cycle delay of `chain_x`. Parameters are the defaults.
- Single sample 0x1234 accepted at cycle 10 → `chain_x`=0x1234 at 11, `out_valid`=1 with `out_data`=0x1234 at 36, exactly one output.
- 100 back-to-back samples 0x0001..0x0064 with `out_ready`=1 → `in_ready` stays 1, outputs are in order and contiguous, and the first appears `CHAIN_LAT`+2 after the first accept.
- `out_ready`=0 with continuous input → exactly 32 samples accepted and then `in_ready`=0. Raise `out_ready` → 32 outputs drain in order, then input resumes; no FIFO overflow.
- Accept 0x0AAA with `flush` in the same cycle (macro defined) → sample taken, then `flush_busy` high for 7 cycles, and 8 outputs total: 0x0AAA then seven 0x0000.
- `rstn` low for 1 cycle while 10 samples are in flight → all outputs return to reset values, and no stale `out_valid` appears afterwards.
- Macro undefined: pulse `flush` in RUN → `flush_busy` stays 0 and `in_ready` is unaffected.
